// File: rtl/scan_xchg_ctrl.sv
// rtl/scan_xchg_ctrl.sv - byte-stream to scan-chain exchange controller
//
// Serialises host bytes into the scan chain MSB first. At the same time it
// captures the bits the chain shifts out and returns them as bytes, so one
// pass swaps the whole image. Both byte streams use valid/ready handshakes.
// The chain is enabled only in the eight cycles that shift each byte.
// A host stall on either side therefore holds the chain frozen.

module scan_xchg_ctrl #(
  parameter int CHAIN_LEN = 168,
  parameter int NBYTES    = CHAIN_LEN / 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  output logic       busy_out,
  output logic       done_out,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       scan_en_out,
  output logic       scan_in_out,
  input  logic       scan_out_in
);

  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [BW-1:0] BYTE_ONE  = 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_PUSH  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]    state;
  logic [7:0]    tx_sh;     // outgoing byte; bit 7 drives the chain
  logic [6:0]    rx_sh;     // first seven captured bits of the current byte
  logic [2:0]    bit_cnt;   // shift cycles completed within the current byte
  logic [BW-1:0] byte_cnt;  // bytes fully returned to the host

  // Exchange sequencer: fetch byte, shift eight bits, push captured byte
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      tx_sh     <= 8'd0;
      rx_sh     <= 7'd0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            byte_cnt <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            tx_sh   <= in_data;
            bit_cnt <= 3'd0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // scan_out_in is sampled before this edge moves the chain, so the
          // chain's current MSB is captured first.
          tx_sh   <= {tx_sh[6:0], 1'b0};
          rx_sh   <= {rx_sh[5:0], scan_out_in};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            out_data  <= {rx_sh, scan_out_in};
            out_valid <= 1'b1;
            state     <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            byte_cnt  <= byte_cnt + BYTE_ONE;
            state     <= (byte_cnt == BYTE_LAST) ? S_FIN : S_FETCH;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and handshake outputs decode straight from the state register.
  // Reset then clears them at once, without waiting for a clock edge.
  always_comb begin
    busy_out    = (state != S_IDLE);
    done_out    = (state == S_FIN);
    in_ready    = (state == S_FETCH);
    scan_en_out = (state == S_SHIFT);
    scan_in_out = (state == S_SHIFT) & tx_sh[7];
  end

endmodule

// File: tb/tb_scan_xchg_ctrl.sv
// tb/tb_scan_xchg_ctrl.sv - scoreboard bench for scan_xchg_ctrl against a chain model

module tb_scan_xchg_ctrl;

  localparam int L  = 168;
  localparam int NB = L / 8;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start_in = 1'b0;
  logic       busy_out, done_out;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       scan_en_out, scan_in_out, scan_out_in;

  scan_xchg_ctrl #(.CHAIN_LEN(L)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .busy_out(busy_out), .done_out(done_out),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .scan_en_out(scan_en_out), .scan_in_out(scan_in_out), .scan_out_in(scan_out_in)
  );

  always #5 clk_in = ~clk_in;

  // Core scan chain stand-in: shifts toward the MSB while enabled.
  logic [L-1:0] chain = 168'h5A_C3_0F_96_1E_2D_3C_4B_5A_69_78_87_96_A5_B4_C3_D2_E1_F0_0F_1E;
  assign scan_out_in = chain[L-1];
  always @(posedge clk_in) if (scan_en_out) chain <= {chain[L-2:0], scan_in_out};

  int n_cmp = 0;
  int n_fail = 0;
  int shift_cnt = 0;
  int done_cnt = 0;
  bit stall_en = 1'b0;
  bit gaps_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [L-1:0] ref_img;  // what the chain is expected to hold right now

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [L-1:0] rnd_img();
    logic [191:0] t;
    for (int k = 0; k < 6; k++) t[k*32 +: 32] = $urandom;
    return t[L-1:0];
  endfunction

  always @(posedge clk_in) if (scan_en_out) shift_cnt++;

  // Monitor: pops the expected byte whenever the host accepts one
  always @(negedge clk_in) begin
    if (done_out) done_cnt++;
    if (scan_en_out && (in_ready || out_valid)) chk("scan_en_in_stall", 1, 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {160'd0, out_data}, 0);
      else chk("out_byte", {160'd0, out_data}, {160'd0, exp_q.pop_front()});
    end
  end

  // Host receive side: optionally holds out_ready low for runs of up to 5 cycles
  initial begin
    int low_run;
    low_run = 0;
    forever begin
      @(posedge clk_in); #1;
      if (stall_en && low_run < 5 && $urandom_range(0, 2) == 0) begin
        out_ready = 1'b0;
        low_run++;
      end else begin
        out_ready = 1'b1;
        low_run = 0;
      end
    end
  end

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    if (gaps_en) repeat ($urandom_range(0, 4)) @(posedge clk_in);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    forever begin
      @(negedge clk_in);
      if (in_ready) break;
      guard++;
      if (guard > 500) begin
        chk("in_ready_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk_in); #1;
    in_valid = 1'b0;
  endtask

  // One full exchange: the chain's previous image must come back byte by byte
  task automatic do_xchg(input logic [L-1:0] img, input bit poke);
    int guard;
    shift_cnt = 0;
    done_cnt  = 0;
    for (int i = 0; i < NB; i++) exp_q.push_back(ref_img[L-1-8*i -: 8]);
    @(posedge clk_in); #1;
    pulse_start();
    for (int i = 0; i < NB; i++) begin
      if (poke && i == 5) pulse_start();
      send_byte(img[L-1-8*i -: 8]);
    end
    guard = 0;
    while (done_cnt == 0 && guard < 200) begin
      @(negedge clk_in);
      guard++;
    end
    repeat (3) @(negedge clk_in);
    chk("done_pulses", done_cnt, 1);
    chk("shift_cycles", shift_cnt, L);
    chk("chain_image", chain, img);
    chk("bytes_left", exp_q.size(), 0);
    chk("busy_after", {167'd0, busy_out}, 0);
    ref_img = img;
  endtask

  initial begin
    logic [L-1:0] img_a, img_d;
    int guard;
    img_a = {8'h21, 8'hE0, 8'h01,
             8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 80'd0, 8'hF0,
             16'hA55A};
    ref_img = chain;

    #3;
    chk("rst_busy", {167'd0, busy_out}, 0);
    chk("rst_done", {167'd0, done_out}, 0);
    chk("rst_in_ready", {167'd0, in_ready}, 0);
    chk("rst_out_valid", {167'd0, out_valid}, 0);
    chk("rst_scan_en", {167'd0, scan_en_out}, 0);
    chk("rst_scan_in", {167'd0, scan_in_out}, 0);
    chk("rst_out_data", {160'd0, out_data}, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    do_xchg(img_a, 1'b0);     // load a known image
    stall_en = 1'b1; gaps_en = 1'b1;
    do_xchg('0, 1'b0);         // returns the loaded image under stalls
    do_xchg(rnd_img(), 1'b1);  // start pulsed while busy must be ignored
    stall_en = 1'b0; gaps_en = 1'b0;
    do_xchg(rnd_img(), 1'b0);

    // Reset during byte 3, after 4 of its bits have been shifted
    img_d = rnd_img();
    shift_cnt = 0;
    for (int i = 0; i < NB; i++) exp_q.push_back(ref_img[L-1-8*i -: 8]);
    @(posedge clk_in); #1;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(img_d[L-1-8*i -: 8]);
    guard = 0;
    while (shift_cnt < 28 && guard < 100) begin
      @(negedge clk_in);
      guard++;
    end
    chk("mid_shift_count", shift_cnt, 28);
    chk("mid_scan_en", {167'd0, scan_en_out}, 1);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_busy", {167'd0, busy_out}, 0);
    chk("mid_rst_scan_en", {167'd0, scan_en_out}, 0);
    chk("mid_rst_scan_in", {167'd0, scan_in_out}, 0);
    chk("mid_rst_in_ready", {167'd0, in_ready}, 0);
    chk("mid_rst_out_valid", {167'd0, out_valid}, 0);
    chk("mid_rst_out_data", {160'd0, out_data}, 0);
    exp_q.delete();
    ref_img = (ref_img << 28) | (img_d >> (L - 28));
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    stall_en = 1'b1; gaps_en = 1'b1;
    do_xchg(rnd_img(), 1'b0);  // returns the partially shifted chain
    for (int r = 0; r < 3; r++) do_xchg(rnd_img(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_xchg_ctrl.md
Name: scan_xchg_ctrl

Overview:
Byte-oriented controller sitting directly upstream of the qtcore scan chain in the lucaz97_tt_top datapath. It serialises a host-supplied image (state/PC/IR/ACC/memory/IO/16-bit key) into scan_in, MSB of the chain first, while capturing scan_out into bytes returned to the host. This gives hardware the same full-chain exchange the bench performs bit by bit, with ready/valid flow control on both byte streams.

Parameters:
CHAIN_LEN, 168, scan chain length in bits (24 + 16*8 + 16); must be a multiple of 8
NBYTES, CHAIN_LEN/8, derived byte count per exchange (21 by default)

Ports:
clk_in  input  1  clock; also clocks the scan chain
rst_in  input  1  asynchronous reset, active-high
start_in  input  1  one-cycle pulse; begins an exchange when idle
busy_out  output  1  high from the accepted start until done_out
done_out  output  1  one-cycle pulse after the last byte is pushed out
in_valid  input  1  host byte valid
in_data  input  8  host byte; first byte holds chain bits [CHAIN_LEN-1 -: 8]
in_ready  output  1  byte accepted when in_valid && in_ready
out_valid  output  1  captured byte valid
out_data  output  8  captured byte; first byte holds old chain bits [CHAIN_LEN-1 -: 8]
out_ready  input  1  host accepts out_data when out_valid && out_ready
scan_en_out  output  1  scan enable to core; high only in cycles that shift
scan_in_out  output  1  serial data into chain
scan_out_in  input  1  serial data from chain

Behaviour:
- Reset (async, any state): state IDLE; busy_out, done_out, in_ready, out_valid, scan_en_out, scan_in_out = 0; out_data = 0; counters = 0.
- States: IDLE, FETCH, SHIFT, PUSH, FIN.
- IDLE: start_in -> FETCH, byte_cnt = 0. start_in is ignored in any other state.
- FETCH: in_ready = 1. When in_valid, latch in_data into tx_sh, bit_cnt = 0 -> SHIFT. With no byte, wait with scan_en_out = 0, so the chain holds.
- SHIFT: 8 cycles with scan_en_out = 1.
  - scan_in_out = tx_sh[7], combinationally valid in the same cycle.
  - On each rising edge: tx_sh <<= 1; rx_sh = {rx_sh[6:0], scan_out_in}, sampling the pre-edge value, i.e. the bit the chain presents before shifting.
  - After the 8th edge: out_data = rx_sh, out_valid = 1 -> PUSH.
- PUSH: hold out_valid/out_data until out_ready; scan_en_out = 0.
  - On accept: out_valid = 0, byte_cnt++.
  - If byte_cnt was NBYTES-1 -> FIN, otherwise -> FETCH.
- FIN: done_out = 1 for one cycle, busy_out = 0 from the next cycle -> IDLE.
- Bit order: a bit presented first ends up at chain MSB after CHAIN_LEN shifts. After one full exchange the chain holds exactly the supplied image, and the returned bytes equal the previous chain contents in the same byte order.
- Shift cycles per exchange = CHAIN_LEN exactly. Stalls never produce an extra or missing shift.
- scan_en_out is never high outside SHIFT. External proc_en must be held low while busy_out; this block does not gate it.
- Reset mid-exchange abandons the transfer. The chain holds a partially shifted image; the next exchange must resend the full image.

Test Plan:
- Load: reset, start, feed 21 bytes for state=001, PC=1, IR=E0, ACC=01, MEM0..4=E0..E4, IO=F0, key=correct -> exactly 168 scan_en_out cycles; core internal regs match; led_out=7'b1111000; done_out single pulse.
- Unload: after running 8 cycles (ACC=0x0B), exchange all-zero bytes -> returned bytes decode to state=001, PC=5, IR=E4, ACC=0B, MEM0..4=E0..E4.
- Back-to-back: exchange image A, then image B -> second exchange returns A bit-exact; chain then holds B.
- Stalls: random gaps on in_valid and random out_ready low for up to 5 cycles -> still 168 shift cycles; data identical to the no-stall run; scan_en_out=0 during every stall.
- Reset mid-SHIFT (after byte 3, bit 4): all outputs 0 immediately (asynchronously); start_in still accepted cleanly afterwards; a full exchange then restores the correct image.
- start_in pulsed while busy -> ignored; byte_cnt and shift count unaffected.
